// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC hit merger.
package tdc_pkg;

  localparam int unsigned NUM_DECODE = 8;

  // Coarse + start + stop fields of one merged word
  localparam int unsigned DIG_OUT = 3 * NUM_DECODE;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_PEND   = 3'd3,
    ST_CLR    = 3'd4
  } chan_state_e;

  // Per-channel captured payload handed to the arbiter
  typedef struct packed {
    logic                  ovf;
    logic [NUM_DECODE-1:0] coarse;
    logic [NUM_DECODE-1:0] start;
    logic [NUM_DECODE-1:0] stop;
  } chan_data_t;

  // Channel-id width, never below one bit
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Merged word width: {ovf, ch_id, coarse, start, stop}
  function automatic int unsigned out_w(input int unsigned n);
    return 1 + ch_w(n) + DIG_OUT;
  endfunction

endpackage

// File: rtl/tdc_merge_chan.sv
// One TDC channel: edge capture, synchronisers, sequencing FSM, code storage.
// Optional start-to-stop timeout enabled by TDC_MERGE_TIMEOUT_EN.
module tdc_merge_chan
  import tdc_pkg::*;
#(
  parameter int unsigned SETTLE = 4
`ifdef TDC_MERGE_TIMEOUT_EN
  ,
  parameter int unsigned TMO_W  = 8
`endif
) (
  input  logic                  clk,
  input  logic                  irst_n,
  input  logic                  rst_n,
  input  logic                  rise,
  input  logic                  fall,
  input  logic [NUM_DECODE-1:0] start_code,
  input  logic [NUM_DECODE-1:0] stop_code,
  input  logic [NUM_DECODE-1:0] coarse,
  input  logic                  grant,
  output logic                  req,
  output logic                  done,
  output logic                  busy,
  output chan_data_t            data
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  chan_state_e state;
  logic [7:0]  settle_cnt;
  logic        rise_flag;
  logic        fall_flag;
  logic        clr_n;
  logic [1:0]  rise_sync;
  logic [1:0]  fall_sync;
  logic        rise_s;
  logic        fall_s;

`ifdef TDC_MERGE_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  // Flags re-arm only once the channel has handed off its word
  assign clr_n = irst_n & ~done;

  // Start-edge flag, clocked by the hit itself
  always_ff @(posedge rise or negedge clr_n) begin
    if (!clr_n) rise_flag <= 1'b0;
    else        rise_flag <= 1'b1;
  end

  // Stop-edge flag, clocked by the hit itself
  always_ff @(posedge fall or negedge clr_n) begin
    if (!clr_n) fall_flag <= 1'b0;
    else        fall_flag <= 1'b1;
  end

  // Two-flop synchronisers; flushed with done so a cleared flag is not seen stale in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_sync <= '0;
      fall_sync <= '0;
    end else if (done) begin
      rise_sync <= '0;
      fall_sync <= '0;
    end else begin
      rise_sync <= {rise_sync[0], rise_flag};
      fall_sync <= {fall_sync[0], fall_flag};
    end
  end

  assign rise_s = rise_sync[1];
  assign fall_s = fall_sync[1];

  // Channel sequencer with registered req/done/busy and captured codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      req        <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      data       <= '0;
`ifdef TDC_MERGE_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall_s) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            busy       <= 1'b1;
            data.stop  <= stop_code;
            if (rise_s) data.start <= start_code;
          end else if (rise_s) begin
            state      <= ST_ARMED;
            busy       <= 1'b1;
            data.start <= start_code;
          end
        end
        ST_ARMED: begin
          if (fall_s) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            data.stop  <= stop_code;
          end
`ifdef TDC_MERGE_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state       <= ST_PEND;
            req         <= 1'b1;
            data.ovf    <= 1'b1;
            data.coarse <= coarse;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state       <= ST_PEND;
            req         <= 1'b1;
            data.coarse <= coarse;
          end
        end
        ST_PEND: begin
          if (grant) begin
            state <= ST_CLR;
            req   <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_CLR: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          settle_cnt <= '0;
          data       <= '0;
`ifdef TDC_MERGE_TIMEOUT_EN
          tmo_cnt    <= '0;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tdc_merge_multi.sv
// Multi-channel TDC hit merger: per-channel capture plus a round-robin
// arbiter feeding one valid/ready output register.
// Optional ARMED timeout enabled by TDC_MERGE_TIMEOUT_EN.
module tdc_merge_multi
  import tdc_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned SETTLE = 4,
  parameter  int unsigned TMO_W  = 8,
  localparam int unsigned CH_W   = ch_w(NUM_CH),
  localparam int unsigned OUT_W  = out_w(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         irst_n,
  input  logic [NUM_CH-1:0]            rise,
  input  logic [NUM_CH-1:0]            fall,
  input  logic [NUM_CH*NUM_DECODE-1:0] StartEdge,
  input  logic [NUM_CH*NUM_DECODE-1:0] FallEdge,
  input  logic [NUM_CH*NUM_DECODE-1:0] Coarse,
  output logic [OUT_W-1:0]             out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH-1:0]            done,
  output logic [NUM_CH-1:0]            busy
);

  // Elaboration-time range checks on the configuration
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("NUM_CH must be 1..16");
  end
  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("SETTLE must be 1..255");
  end
  if (TMO_W < 1 || TMO_W > 31) begin : g_bad_tmo_w
    $error("TMO_W must be 1..31");
  end

  logic [1:0]        rst_pipe;
  logic              rst_n;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant_c;
  logic              gnt_any_c;
  logic [CH_W-1:0]   gnt_idx_c;
  logic [CH_W-1:0]   rr_ptr;
  int unsigned       idx_c;
  chan_data_t        chan_data [NUM_CH];
  chan_data_t        sel_c;

  // Reset asserts immediately, releases synchronously to clk
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) rst_pipe <= '0;
    else         rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    tdc_merge_chan #(
      .SETTLE     (SETTLE)
`ifdef TDC_MERGE_TIMEOUT_EN
      ,
      .TMO_W      (TMO_W)
`endif
    ) u_chan (
      .clk        (clk),
      .irst_n     (irst_n),
      .rst_n      (rst_n),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .start_code (StartEdge[i*NUM_DECODE +: NUM_DECODE]),
      .stop_code  (FallEdge[i*NUM_DECODE +: NUM_DECODE]),
      .coarse     (Coarse[i*NUM_DECODE +: NUM_DECODE]),
      .grant      (grant_c[i]),
      .req        (req[i]),
      .done       (done[i]),
      .busy       (busy[i]),
      .data       (chan_data[i])
    );
  end

  // Round-robin pick of one pending channel, only when the output slot frees
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_idx_c = '0;
    grant_c   = '0;
    idx_c     = 0;
    if (!out_valid || out_ready) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        idx_c = (32'(rr_ptr) + k) % NUM_CH;
        if (!gnt_any_c && req[CH_W'(idx_c)]) begin
          gnt_any_c = 1'b1;
          gnt_idx_c = CH_W'(idx_c);
        end
      end
    end
    if (gnt_any_c) grant_c = NUM_CH'(1) << gnt_idx_c;
    sel_c = chan_data[gnt_idx_c];
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= '0;
    end else if (gnt_any_c) begin
      out       <= {sel_c.ovf, gnt_idx_c, sel_c.coarse, sel_c.start, sel_c.stop};
      out_valid <= 1'b1;
      rr_ptr    <= (gnt_idx_c == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_c + CH_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_merge_multi.sv
// Scoreboard bench for tdc_merge_multi (NUM_CH=4, SETTLE=4, TMO_W=4).
// Timeout expectations follow TDC_MERGE_TIMEOUT_EN.
module tb_tdc_merge_multi;
  import tdc_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO_W  = 4;
  localparam int unsigned ND     = NUM_DECODE;
  localparam int unsigned CH_W   = ch_w(NUM_CH);
  localparam int unsigned OUT_W  = out_w(NUM_CH);

  logic                   clk;
  logic                   irst_n;
  logic [NUM_CH-1:0]      rise;
  logic [NUM_CH-1:0]      fall;
  logic [NUM_CH*ND-1:0]   StartEdge;
  logic [NUM_CH*ND-1:0]   FallEdge;
  logic [NUM_CH*ND-1:0]   Coarse;
  logic [OUT_W-1:0]       out;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_CH-1:0]      done;
  logic [NUM_CH-1:0]      busy;

  logic [ND-1:0]    st_code [NUM_CH];
  logic [ND-1:0]    sp_code [NUM_CH];
  logic [ND-1:0]    co_code [NUM_CH];
  logic [OUT_W-1:0] exp_q [$];
  int               acc_cyc [$];
  int               done_cnt [NUM_CH];
  int               cyc;
  int               checks;
  int               errors;
  int unsigned      mdl_ptr;

  tdc_merge_multi #(
    .NUM_CH    (NUM_CH),
    .SETTLE    (SETTLE),
    .TMO_W     (TMO_W)
  ) dut (
    .clk       (clk),
    .irst_n    (irst_n),
    .rise      (rise),
    .fall      (fall),
    .StartEdge (StartEdge),
    .FallEdge  (FallEdge),
    .Coarse    (Coarse),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    StartEdge = '0;
    FallEdge  = '0;
    Coarse    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      StartEdge[i*ND +: ND] = st_code[i];
      FallEdge[i*ND +: ND]  = sp_code[i];
      Coarse[i*ND +: ND]    = co_code[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] mk_word(input logic ovf, input int unsigned ch,
                                               input logic [ND-1:0] co, input logic [ND-1:0] st,
                                               input logic [ND-1:0] sp);
    return {ovf, CH_W'(ch), co, st, sp};
  endfunction

  // Expected word for one channel; advances the model round-robin pointer
  task automatic push_word(input logic ovf, input int unsigned ch, input logic [ND-1:0] st,
                           input logic [ND-1:0] sp);
    exp_q.push_back(mk_word(ovf, ch, co_code[ch], st, sp));
    mdl_ptr = (ch + 1) % NUM_CH;
  endtask

  // Fall-only hits on several channels pending together: round-robin order from model pointer
  task automatic push_burst(input logic [NUM_CH-1:0] set);
    int unsigned p;
    p = mdl_ptr;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int unsigned idx;
      idx = (p + k) % NUM_CH;
      if (set[idx]) push_word(1'b0, idx, '0, sp_code[idx]);
    end
  endtask

  // Scoreboard: pop and compare on every accepted word
  always @(negedge clk) begin
    if (irst_n) begin
      cyc++;
      for (int i = 0; i < NUM_CH; i++) if (done[i]) done_cnt[i]++;
      if (out_valid && out_ready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_word_sb_depth", 64'(exp_q.size()), 64'(1));
        else check("word", 64'(out), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] r, input logic [NUM_CH-1:0] f);
    @(posedge clk);
    #1;
    rise = r;
    fall = f;
    #2;
    rise = '0;
    fall = '0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (busy == '0 && !out_valid && exp_q.size() == 0) break;
      step(1);
    end
    check({tag, "_idle"}, 64'({busy, out_valid}), 64'(0));
    check({tag, "_sb_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    irst_n = 1'b0;
    step(3);
    irst_n = 1'b1;
    step(5);
    mdl_ptr = 0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n0;
    int d0;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    mdl_ptr   = 0;
    irst_n    = 1'b0;
    rise      = '0;
    fall      = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      st_code[i]  = ND'(32'hA5 + 32'(i) * 17);
      sp_code[i]  = ND'(32'h3C + 32'(i) * 29);
      co_code[i]  = ND'(32'h71 + 32'(i) * 13);
      done_cnt[i] = 0;
    end

    // Reset state
    #12;
    check("rst_out", 64'(out), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    step(2);
    irst_n = 1'b1;
    step(5);

    // Single hit on ch0: rise, fall 10 cycles later
    d0 = done_cnt[0];
    push_word(1'b0, 0, st_code[0], sp_code[0]);
    pulse(4'b0001, 4'b0000);
    step(10);
    check("single_busy", 64'(busy), 64'(1));
    pulse(4'b0000, 4'b0001);
    lat = 0;
    while (!out_valid && lat < 100) begin
      step(1);
      lat++;
    end
    check("single_latency_min", 64'(lat >= 2 + SETTLE + 2), 64'(1));
    wait_idle("single", 100);
    check("single_done_pulses", 64'(done_cnt[0] - d0), 64'(1));

    // Contention: four simultaneous falls from a fresh pointer, order 0,1,2,3
    do_reset();
    n0 = acc_cyc.size();
    push_burst(4'b1111);
    pulse(4'b0000, 4'b1111);
    wait_idle("burst0", 100);
    for (int k = 1; k < 4; k++) check("burst0_gap", 64'(acc_cyc[n0+k] - acc_cyc[n0+k-1]), 64'(1));

    // Move pointer with a lone ch1 hit, then a repeat burst resumes after it
    push_burst(4'b0010);
    pulse(4'b0000, 4'b0010);
    wait_idle("lone1", 100);
    n0 = acc_cyc.size();
    push_burst(4'b1111);
    pulse(4'b0000, 4'b1111);
    wait_idle("burst1", 100);
    for (int k = 1; k < 4; k++) check("burst1_gap", 64'(acc_cyc[n0+k] - acc_cyc[n0+k-1]), 64'(1));

    // Backpressure: two words pending with out_ready low for 20 cycles
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    push_burst(4'b0101);
    pulse(4'b0000, 4'b0101);
    step(14);
    n0 = acc_cyc.size();
    for (int k = 0; k < 20; k++) begin
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_stable", 64'(out), 64'(exp_q[0]));
      step(1);
    end
    out_ready = 1'b1;
    wait_idle("bp", 100);
    check("bp_accepts", 64'(acc_cyc.size() - n0), 64'(2));
    check("bp_gap", 64'(acc_cyc[n0+1] - acc_cyc[n0]), 64'(1));

    // Timeout: rise on ch1 with no fall
`ifdef TDC_MERGE_TIMEOUT_EN
    push_word(1'b1, 1, st_code[1], '0);
    pulse(4'b0010, 4'b0000);
    lat = 0;
    while (!out_valid && lat < 200) begin
      step(1);
      lat++;
    end
    check("tmo_latency_min", 64'(lat >= (1 << TMO_W) - 1), 64'(1));
    wait_idle("tmo", 100);
`else
    n0 = acc_cyc.size();
    pulse(4'b0010, 4'b0000);
    step(40);
    check("tmo_stays_busy", 64'(busy), 64'(4'b0010));
    check("tmo_no_word", 64'(acc_cyc.size() - n0), 64'(0));
`endif

    // Reset during SETTLE of ch1
    do_reset();
    n0 = acc_cyc.size();
    pulse(4'b0000, 4'b0010);
    step(4);
    check("rst_mid_busy_before", 64'(busy), 64'(4'b0010));
    irst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_out", 64'(out), 64'(0));
    step(3);
    irst_n = 1'b1;
    step(30);
    check("rst_mid_no_word", 64'(acc_cyc.size() - n0), 64'(0));
    check("rst_mid_idle", 64'({busy, out_valid}), 64'(0));

    check("final_sb_left", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
